// File: rtl/cc_pkg.sv
// Shared constants and the fill FSM state type for the critical-word fill packer.
package cc_pkg;
  localparam int LINE_W   = 512;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 8;
  localparam int OFFSET_W = 6;
  localparam int FIFO_W   = OFFSET_W + LINE_W;  // 518
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PUSH = 2'd2
  } fill_state_e;
endpackage

// File: rtl/cc_fill_packer.sv
// cc_fill_packer: assembles a cache line either from an 8-beat memory burst
// (miss) or from a full-line hit read, and pushes {offset, line} into the
// read-data FIFO. The offset is carried through untouched; critical-word
// rotation happens downstream.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   miss_valid_i/offset_i miss request; miss_ready_o accepts it (IDLE only)
//   mem_rdata_i/rvalid_i  read-data beats, word 0 first; mem_rready_o in FILL
//   mem_rlast_i           burst end marker, checked against the beat count
//   hit_valid_i/data_i    full line from the data array; hit_ready_o accepts
//   hit_offset_i            it in IDLE when no miss is pending
//   fifo_full_i           FIFO backpressure
//   fifo_wren_o/wdata_o   registered FIFO push, wdata = {offset, line}
//   err_o                 sticky burst-protocol error
module cc_fill_packer
  import cc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_valid_i,
  input  logic [OFFSET_W-1:0] miss_offset_i,
  output logic                miss_ready_o,
  input  logic [BEAT_W-1:0]   mem_rdata_i,
  input  logic                mem_rvalid_i,
  input  logic                mem_rlast_i,
  output logic                mem_rready_o,
  input  logic                hit_valid_i,
  input  logic [LINE_W-1:0]   hit_data_i,
  input  logic [OFFSET_W-1:0] hit_offset_i,
  output logic                hit_ready_o,
  input  logic                fifo_full_i,
  output logic                fifo_wren_o,
  output logic [FIFO_W-1:0]   fifo_wdata_o,
  output logic                err_o
);

  fill_state_e state_q, state_d;

  // Line storage doubles as the FIFO write-data register, so wdata is
  // registered by construction and cannot change while PUSH holds.
  // Word k lives in element BEATS-1-k so word 0 lands in the top 64 bits.
  logic [BEATS-1:0][BEAT_W-1:0] line_q;
  logic [OFFSET_W-1:0]          off_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         wren_q, wren_d;
  logic                         err_q;

  logic miss_acc, hit_acc, beat_acc, last_beat, rlast_bad;
  logic [CNT_W-1:0] widx;

  assign miss_acc  = (state_q == ST_IDLE) && miss_valid_i;
  assign hit_acc   = (state_q == ST_IDLE) && !miss_valid_i && hit_valid_i;
  assign beat_acc  = (state_q == ST_FILL) && mem_rvalid_i;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign rlast_bad = last_beat ? !mem_rlast_i : mem_rlast_i;
  assign widx      = CNT_W'(BEATS - 1) - cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid_i)     state_d = ST_FILL;
        else if (hit_valid_i) state_d = ST_PUSH;
      end
      // Beat 7 ends the fill whatever rlast says; rlast only feeds err.
      ST_FILL: if (beat_acc && last_beat) state_d = ST_PUSH;
      ST_PUSH: if (wren_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready decode
  always_comb begin
    miss_ready_o = 1'b0;
    hit_ready_o  = 1'b0;
    mem_rready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miss_ready_o = 1'b1;
        hit_ready_o  = !miss_valid_i;
      end
      ST_FILL: mem_rready_o = 1'b1;
      default: ;
    endcase
  end

  // The write strobe is registered, so the full flag is looked at one cycle
  // ahead: the strobe is armed on the cycle that completes the line (or on a
  // stalled PUSH cycle) whenever the FIFO is not full at that point.
  always_comb begin
    wren_d = 1'b0;
    if (hit_acc || (beat_acc && last_beat) || (state_q == ST_PUSH && !wren_q))
      wren_d = !fifo_full_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
      wren_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wren_q <= wren_d;
      if (miss_acc) begin
        off_q <= miss_offset_i;
        cnt_q <= '0;
      end else if (hit_acc) begin
        off_q  <= hit_offset_i;
        line_q <= hit_data_i;
      end
      if (beat_acc) begin
        line_q[widx] <= mem_rdata_i;
        cnt_q        <= cnt_q + CNT_W'(1);
        if (rlast_bad) err_q <= 1'b1;
      end
    end
  end

  assign fifo_wren_o  = wren_q;
  assign fifo_wdata_o = {off_q, line_q};
  assign err_o        = err_q;

endmodule

// File: doc/cc_fill_packer.md
CC_FILL_PACKER -- requirements
Module: cc_fill_packer

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: miss_valid_i  input  1 / miss_offset_i  input  6 / miss_ready_o  output  1; miss request with byte offset; offset[5:3] is the critical word index.
REQ-004 SHALL have: mem_rdata_i  input  64 / mem_rvalid_i  input  1 / mem_rlast_i  input  1 / mem_rready_o  output  1; memory read-data beats, word 0 first.
REQ-005 SHALL have: hit_valid_i  input  1 / hit_data_i  input  512 / hit_offset_i  input  6 / hit_ready_o  output  1; full line from the data array on a hit.
REQ-006 SHALL have: fifo_full_i  input  1 / fifo_wren_o  output  1 / fifo_wdata_o  output  518; push port of the read-data FIFO; wdata = {offset[5:0], line[511:0]}.
REQ-007 SHALL have: err_o  output  1; sticky burst-protocol error flag.

Function
REQ-008 SHALL implement FSM states IDLE, FILL, PUSH; reset state IDLE.
REQ-009 IDLE: miss_ready_o=1, hit_ready_o=!miss_valid_i; miss handshake has priority over hit when both valid.
REQ-010 Miss handshake in IDLE SHALL latch miss_offset_i, clear beat counter to 0, go to FILL.
REQ-011 Hit handshake in IDLE SHALL latch hit_data_i and hit_offset_i into the line/offset registers, go to PUSH.
REQ-012 FILL: mem_rready_o=1, miss_ready_o=0, hit_ready_o=0; mem_rready_o=0 in all other states.
REQ-013 Each accepted beat k (k=0..7, 3-bit counter) SHALL be written to line[511-64k -: 64]; word 0 occupies [511:448], word 7 occupies [63:0].
REQ-014 After beat 7 is accepted, FSM SHALL go to PUSH regardless of mem_rlast_i.
REQ-015 mem_rlast_i=1 on beat k<7, or mem_rlast_i=0 on beat 7, SHALL set err_o; the fill still runs to 8 beats; err_o clears only on reset.
REQ-016 PUSH: fifo_wren_o SHALL be 1 for exactly one cycle, in the first PUSH cycle with fifo_full_i=0; fifo_wdata_o stable throughout PUSH.
REQ-017 PUSH with fifo_full_i=1 SHALL hold state, fifo_wren_o=0, line data unchanged; no ready asserted.
REQ-018 After the write cycle FSM SHALL return to IDLE; a new request is accepted the cycle after that write.
REQ-019 Latency: hit accepted in cycle N -> fifo_wren_o in cycle N+1 if FIFO not full; beat 7 accepted in cycle N -> fifo_wren_o in cycle N+1 if FIFO not full.
REQ-020 fifo_wren_o, fifo_wdata_o, err_o SHALL be registered; ready outputs are decoded from the state register only.
REQ-021 Beats with mem_rvalid_i=1 outside FILL SHALL be ignored and not set err_o.
REQ-022 Offset SHALL pass unmodified; no critical-word rotation occurs here (the downstream serializer performs it).

Reset
REQ-023 rst_n=0 SHALL force: state IDLE, beat counter 0, fifo_wren_o=0, fifo_wdata_o=0, err_o=0; line/offset registers cleared.
REQ-024 Reset during FILL or PUSH SHALL discard the partial or pending line; no FIFO write occurs for it.

Structure
REQ-025 Shared package cc_pkg SHALL hold: LINE_W=512, BEAT_W=64, BEATS=8, OFFSET_W=6, FIFO_W=518, and the fill FSM state enum.
REQ-026 Single module, no sub-modules; line assembly is an in-module register array indexed by the beat counter.

Verification
REQ-027 Miss offset 6'h18, beats 64'h0..64'h7 with rlast on beat 7, FIFO empty -> one wren; wdata[517:512]=6'h18, [511:448]=0, [63:0]=7; err_o=0.
REQ-028 Hit with data=512'hA5.., offset 6'h38 -> wren exactly 1 cycle later, wdata={6'h38, hit data}.
REQ-029 miss_valid_i and hit_valid_i both high in IDLE -> miss accepted, hit_ready_o=0 until return to IDLE; hit then pushed after the miss line.
REQ-030 fifo_full_i held high 5 cycles in PUSH -> no wren, wdata stable; on release, exactly one wren.
REQ-031 rlast on beat 3 -> err_o=1 stays set; 8 beats still collected; one wren.
REQ-032 rst_n low after beat 4 of a fill -> no wren, all outputs 0, next miss fills correctly from beat 0.
